aud_slot_ctrl: RTL and testbench



---
 rtl/aud_slot_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_aud_slot_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aud_slot_ctrl.sv
// Multi-slot record/playback controller for the WM8731 path: owns the SRAM address
// and write strobe, tracks per-slot recorded length and elapsed seconds per mode.
module aud_slot_ctrl #(
    parameter int ADDR_W        = 20,
    parameter int SLOT_BITS     = 2,
    parameter int TICKS_PER_SEC = 32000,
    parameter int TIME_W        = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_i2c_done,
    input  logic                 i_key_rec,
    input  logic                 i_key_play,
    input  logic                 i_key_stop,
    input  logic [SLOT_BITS-1:0] i_slot_sel,
    input  logic                 i_loop,
    input  logic                 i_rec_strobe,
    input  logic                 i_play_strobe,
    output logic [2:0]           o_state,
    output logic                 o_i2c_start,
    output logic [ADDR_W-1:0]    o_sram_addr,
    output logic                 o_sram_we_n,
    output logic                 o_rec_start,
    output logic                 o_rec_pause,
    output logic                 o_rec_stop,
    output logic                 o_dsp_start,
    output logic                 o_dsp_pause,
    output logic                 o_dsp_stop,
    output logic [TIME_W-1:0]    o_rec_time,
    output logic [TIME_W-1:0]    o_play_time,
    output logic                 o_full
);
    localparam int OFF_W  = ADDR_W - SLOT_BITS;
    localparam int LEN_W  = OFF_W + 1;
    localparam int NSLOT  = 1 << SLOT_BITS;
    localparam int TICK_W = $clog2(TICKS_PER_SEC + 1);

    localparam logic [LEN_W-1:0]  SLOT_SIZE = {1'b1, {OFF_W{1'b0}}};
    localparam logic [LEN_W-1:0]  LEN_ONE   = {{OFF_W{1'b0}}, 1'b1};
    localparam logic [OFF_W-1:0]  OFF_ONE   = {{(OFF_W-1){1'b0}}, 1'b1};
    localparam logic [OFF_W-1:0]  OFF_LAST  = {OFF_W{1'b1}};
    localparam logic [TICK_W-1:0] TICK_ONE  = {{(TICK_W-1){1'b0}}, 1'b1};
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [TIME_W-1:0] TIME_ONE  = {{(TIME_W-1){1'b0}}, 1'b1};
    localparam logic [TIME_W-1:0] TIME_MAX  = {TIME_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_REC        = 3'd2,
        ST_REC_PAUSE  = 3'd3,
        ST_PLAY       = 3'd4,
        ST_PLAY_PAUSE = 3'd5,
        ST_I2C        = 3'd7
    } state_e;

    state_e               state_q, state_d;
    logic [SLOT_BITS-1:0] slot_q, slot_d;
    logic [OFF_W-1:0]     rec_off_q, rec_off_d, play_off_q, play_off_d;
    logic [LEN_W-1:0]     len_q [NSLOT];
    logic [LEN_W-1:0]     len_d [NSLOT];
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 we_n_q, we_n_d, full_q, full_d;
    logic [TICK_W-1:0]    rec_tick_q, rec_tick_d, play_tick_q, play_tick_d;
    logic [TIME_W-1:0]    rec_time_q, rec_time_d, play_time_q, play_time_d;
    logic                 i2c_start_q, i2c_start_d;
    logic [2:0]           rec_mode_q, rec_mode_d, dsp_mode_q, dsp_mode_d;
    logic                 rec_acc_s, play_acc_s, rec_clr_s, play_clr_s;
    logic [LEN_W-1:0]     play_nxt_s;

    // Sub-second tick plus saturating seconds; returns {tick, seconds}.
    function automatic logic [TICK_W+TIME_W-1:0] tick_next(
        input logic              clr,
        input logic              acc,
        input logic [TICK_W-1:0] tick,
        input logic [TIME_W-1:0] secs
    );
        logic [TICK_W+TIME_W-1:0] r;
        if (clr) begin
            r = '0;
        end else if (acc && (tick == TICK_LAST)) begin
            r = {{TICK_W{1'b0}}, (secs == TIME_MAX) ? TIME_MAX : secs + TIME_ONE};
        end else if (acc) begin
            r = {tick + TICK_ONE, secs};
        end else begin
            r = {tick, secs};
        end
        return r;
    endfunction

    // Next state, slot/offset/length bookkeeping and SRAM address/strobe generation.
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        rec_off_d  = rec_off_q;
        play_off_d = play_off_q;
        len_d      = len_q;
        addr_d     = addr_q;
        we_n_d     = 1'b1;
        full_d     = 1'b0;
        rec_acc_s  = 1'b0;
        play_acc_s = 1'b0;
        rec_clr_s  = 1'b0;
        play_clr_s = 1'b0;
        play_nxt_s = {1'b0, play_off_q} + LEN_ONE;
        case (state_q)
            ST_I2C: begin
                if (i_i2c_done) state_d = ST_IDLE;
                else            state_d = ST_I2C;
            end
            ST_IDLE: begin
                if (i_key_stop) begin
                    state_d = ST_IDLE;
                end else if (i_key_rec) begin
                    state_d   = ST_REC;
                    slot_d    = i_slot_sel;
                    rec_off_d = '0;
                    rec_clr_s = 1'b1;
                end else if (i_key_play && (len_q[i_slot_sel] != '0)) begin
                    state_d    = ST_PLAY;
                    slot_d     = i_slot_sel;
                    play_off_d = '0;
                    play_clr_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REC, ST_REC_PAUSE: begin
                if (i_key_stop) begin
                    state_d       = ST_IDLE;
                    len_d[slot_q] = {1'b0, rec_off_q};
                end else begin
                    if (i_key_rec) state_d = (state_q == ST_REC) ? ST_REC_PAUSE : ST_REC;
                    else           state_d = state_q;
                    if ((state_q == ST_REC) && i_rec_strobe) begin
                        rec_acc_s = 1'b1;
                        addr_d    = {slot_q, rec_off_q};
                        we_n_d    = 1'b0;
                        rec_off_d = rec_off_q + OFF_ONE;
                        // Last word of the slot: auto-stop wins over a same-cycle pause.
                        if (rec_off_q == OFF_LAST) begin
                            len_d[slot_q] = SLOT_SIZE;
                            state_d       = ST_IDLE;
                            full_d        = 1'b1;
                        end else begin
                            full_d = 1'b0;
                        end
                    end else begin
                        rec_acc_s = 1'b0;
                    end
                end
            end
            ST_PLAY, ST_PLAY_PAUSE: begin
                if (i_key_stop) begin
                    state_d = ST_IDLE;
                end else begin
                    if (i_key_play) state_d = (state_q == ST_PLAY) ? ST_PLAY_PAUSE : ST_PLAY;
                    else            state_d = state_q;
                    if ((state_q == ST_PLAY) && i_play_strobe) begin
                        play_acc_s = 1'b1;
                        addr_d     = {slot_q, play_off_q};
                        if (play_nxt_s == len_q[slot_q]) begin
                            if (i_loop) begin
                                play_off_d = '0;
                            end else begin
                                play_off_d = play_nxt_s[OFF_W-1:0];
                                state_d    = ST_IDLE;
                            end
                        end else begin
                            play_off_d = play_nxt_s[OFF_W-1:0];
                        end
                    end else begin
                        play_acc_s = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Mode outputs are decoded from the next state so they register alongside it.
    always_comb begin
        i2c_start_d = 1'b0;
        rec_mode_d  = 3'b001;
        dsp_mode_d  = 3'b001;
        case (state_d)
            ST_I2C:        i2c_start_d = 1'b1;
            ST_REC:        rec_mode_d  = 3'b100;
            ST_REC_PAUSE:  rec_mode_d  = 3'b010;
            ST_PLAY:       dsp_mode_d  = 3'b100;
            ST_PLAY_PAUSE: dsp_mode_d  = 3'b010;
            default:       i2c_start_d = 1'b0;
        endcase
    end

    // Elapsed-time counters for record and playback.
    always_comb begin
        {rec_tick_d, rec_time_d}   = tick_next(rec_clr_s, rec_acc_s, rec_tick_q, rec_time_q);
        {play_tick_d, play_time_d} = tick_next(play_clr_s, play_acc_s, play_tick_q, play_time_q);
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_I2C;
            slot_q      <= '0;
            rec_off_q   <= '0;
            play_off_q  <= '0;
            for (int i = 0; i < NSLOT; i++) len_q[i] <= '0;
            addr_q      <= '0;
            we_n_q      <= 1'b1;
            full_q      <= 1'b0;
            rec_tick_q  <= '0;
            rec_time_q  <= '0;
            play_tick_q <= '0;
            play_time_q <= '0;
            i2c_start_q <= 1'b1;
            rec_mode_q  <= 3'b001;
            dsp_mode_q  <= 3'b001;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            rec_off_q   <= rec_off_d;
            play_off_q  <= play_off_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            we_n_q      <= we_n_d;
            full_q      <= full_d;
            rec_tick_q  <= rec_tick_d;
            rec_time_q  <= rec_time_d;
            play_tick_q <= play_tick_d;
            play_time_q <= play_time_d;
            i2c_start_q <= i2c_start_d;
            rec_mode_q  <= rec_mode_d;
            dsp_mode_q  <= dsp_mode_d;
        end
    end

    assign o_state     = state_q;
    assign o_i2c_start = i2c_start_q;
    assign o_sram_addr = addr_q;
    assign o_sram_we_n = we_n_q;
    assign o_full      = full_q;
    assign o_rec_time  = rec_time_q;
    assign o_play_time = play_time_q;
    assign {o_rec_start, o_rec_pause, o_rec_stop} = rec_mode_q;
    assign {o_dsp_start, o_dsp_pause, o_dsp_stop} = dsp_mode_q;

endmodule

// File: tb/tb_aud_slot_ctrl.sv
// Self-checking bench for aud_slot_ctrl: directed scenarios plus random keys/strobes,
// every cycle compared against a behavioural model built on counts and slot arrays.
module tb_aud_slot_ctrl;
    localparam int ADDR_W    = 8;
    localparam int SLOT_BITS = 2;
    localparam int TPS       = 4;
    localparam int TIME_W    = 3;
    localparam int SLOT_SIZE = 64;
    localparam int TIME_MAX  = 7;

    logic       i_clk = 1'b0;
    logic       i_rst, i_i2c_done, i_key_rec, i_key_play, i_key_stop;
    logic [1:0] i_slot_sel;
    logic       i_loop, i_rec_strobe, i_play_strobe;
    logic [2:0] o_state;
    logic       o_i2c_start, o_sram_we_n, o_full;
    logic [7:0] o_sram_addr;
    logic       o_rec_start, o_rec_pause, o_rec_stop;
    logic       o_dsp_start, o_dsp_pause, o_dsp_stop;
    logic [2:0] o_rec_time, o_play_time;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: spec state numbers, offsets, lengths, accepted-strobe counts.
    int m_state, m_slot, m_roff, m_poff, m_addr, m_we_n, m_full, m_rcnt, m_pcnt;
    int m_len [4];
    bit r_kr, r_kp, r_ks, r_sr, r_sp;

    aud_slot_ctrl #(
        .ADDR_W(ADDR_W), .SLOT_BITS(SLOT_BITS), .TICKS_PER_SEC(TPS), .TIME_W(TIME_W)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_i2c_done(i_i2c_done),
        .i_key_rec(i_key_rec), .i_key_play(i_key_play), .i_key_stop(i_key_stop),
        .i_slot_sel(i_slot_sel), .i_loop(i_loop),
        .i_rec_strobe(i_rec_strobe), .i_play_strobe(i_play_strobe),
        .o_state(o_state), .o_i2c_start(o_i2c_start),
        .o_sram_addr(o_sram_addr), .o_sram_we_n(o_sram_we_n),
        .o_rec_start(o_rec_start), .o_rec_pause(o_rec_pause), .o_rec_stop(o_rec_stop),
        .o_dsp_start(o_dsp_start), .o_dsp_pause(o_dsp_pause), .o_dsp_stop(o_dsp_stop),
        .o_rec_time(o_rec_time), .o_play_time(o_play_time), .o_full(o_full)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at %0t: observed 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 7; m_slot = 0; m_roff = 0; m_poff = 0; m_addr = 0;
        m_we_n = 1; m_full = 0; m_rcnt = 0; m_pcnt = 0;
        for (int s = 0; s < 4; s++) m_len[s] = 0;
    endtask

    function automatic int secs(input int cnt);
        return (cnt / TPS > TIME_MAX) ? TIME_MAX : cnt / TPS;
    endfunction

    task automatic model_step(input bit kr, input bit kp, input bit ks, input bit sr, input bit sp);
        int st;
        st = m_state;
        m_we_n = 1;
        m_full = 0;
        case (st)
            7: if (i_i2c_done) m_state = 0;
            0: begin
                if (!ks && kr) begin
                    m_state = 2; m_slot = int'(i_slot_sel); m_roff = 0; m_rcnt = 0;
                end else if (!ks && kp && m_len[i_slot_sel] != 0) begin
                    m_state = 4; m_slot = int'(i_slot_sel); m_poff = 0; m_pcnt = 0;
                end
            end
            2, 3: begin
                if (ks) begin
                    m_len[m_slot] = m_roff;
                    m_state = 0;
                end else begin
                    if (kr) m_state = (st == 2) ? 3 : 2;
                    if (st == 2 && sr) begin
                        m_addr = m_slot * SLOT_SIZE + m_roff;
                        m_we_n = 0;
                        m_rcnt++;
                        m_roff++;
                        if (m_roff == SLOT_SIZE) begin
                            m_len[m_slot] = SLOT_SIZE; m_roff = 0; m_state = 0; m_full = 1;
                        end
                    end
                end
            end
            4, 5: begin
                if (ks) begin
                    m_state = 0;
                end else begin
                    if (kp) m_state = (st == 4) ? 5 : 4;
                    if (st == 4 && sp) begin
                        m_addr = m_slot * SLOT_SIZE + m_poff;
                        m_pcnt++;
                        m_poff++;
                        if (m_poff == m_len[m_slot]) begin
                            if (i_loop) m_poff = 0;
                            else        m_state = 0;
                        end
                    end
                end
            end
            default: m_state = 0;
        endcase
    endtask

    task automatic check_all();
        check("state",     32'(o_state), 32'(m_state));
        check("i2c_start", 32'(o_i2c_start), 32'(m_state == 7));
        check("addr",      32'(o_sram_addr), 32'(m_addr));
        check("we_n",      32'(o_sram_we_n), 32'(m_we_n));
        check("rec_mode",  32'({o_rec_start, o_rec_pause, o_rec_stop}),
              32'({m_state == 2, m_state == 3, !(m_state == 2 || m_state == 3)}));
        check("dsp_mode",  32'({o_dsp_start, o_dsp_pause, o_dsp_stop}),
              32'({m_state == 4, m_state == 5, !(m_state == 4 || m_state == 5)}));
        check("rec_time",  32'(o_rec_time), 32'(secs(m_rcnt)));
        check("play_time", 32'(o_play_time), 32'(secs(m_pcnt)));
        check("full",      32'(o_full), 32'(m_full));
    endtask

    task automatic cyc(input bit kr, input bit kp, input bit ks, input bit sr, input bit sp);
        i_key_rec = kr; i_key_play = kp; i_key_stop = ks;
        i_rec_strobe = sr; i_play_strobe = sp;
        model_step(kr, kp, ks, sr, sp);
        @(posedge i_clk);
        #1;
        i_key_rec = 1'b0; i_key_play = 1'b0; i_key_stop = 1'b0;
        i_rec_strobe = 1'b0; i_play_strobe = 1'b0;
        check_all();
    endtask

    initial begin
        i_rst = 1'b1; i_i2c_done = 1'b0; i_key_rec = 1'b0; i_key_play = 1'b0;
        i_key_stop = 1'b0; i_slot_sel = 2'd0; i_loop = 1'b0;
        i_rec_strobe = 1'b0; i_play_strobe = 1'b0;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        check_all();
        check("rst_state", 32'(o_state), 32'd7);
        check("rst_we_n", 32'(o_sram_we_n), 32'd1);
        i_rst = 1'b0;

        // Codec init: keys ignored until done.
        for (int i = 0; i < 10; i++) begin
            cyc(i % 3 == 0, i % 3 == 1, i % 3 == 2, 1'b1, 1'b1);
            check("i2c_hold", 32'(o_state), 32'd7);
        end
        i_i2c_done = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("i2c_exit", 32'(o_state), 32'd0);

        // Record 5 words into slot 2, then play them back without loop.
        i_slot_sel = 2'd2;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rec_enter", 32'(o_state), 32'd2);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            check("rec_addr", 32'(o_sram_addr), 32'h80 + i);
            check("rec_we", 32'(o_sram_we_n), 32'd0);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("rec_stop", 32'(o_state), 32'd0);
        check("rec_time_5", 32'(o_rec_time), 32'd1);
        i_loop = 1'b0;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("play_enter", 32'(o_state), 32'd4);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            check("play_addr", 32'(o_sram_addr), 32'h80 + i);
        end
        check("play_end", 32'(o_state), 32'd0);

        // Empty slot refuses to play.
        i_slot_sel = 2'd1;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("play_empty", 32'(o_state), 32'd0);

        // Fill slot 3 completely.
        i_slot_sel = 2'd3;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("full_addr", 32'(o_sram_addr), 32'hFF);
        check("full_pulse", 32'(o_full), 32'd1);
        check("full_state", 32'(o_state), 32'd0);
        check("rec_time_sat", 32'(o_rec_time), 32'd7);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("full_one_cycle", 32'(o_full), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("full_play_end", 32'(o_state), 32'd0);
        check("full_play_addr", 32'(o_sram_addr), 32'hFF);

        // Pause/resume on slot 0.
        i_slot_sel = 2'd0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pause_state", 32'(o_state), 32'd3);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            check("pause_drop_we", 32'(o_sram_we_n), 32'd1);
            check("pause_drop_addr", 32'(o_sram_addr), 32'h02);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            check("resume_addr", 32'(o_sram_addr), 32'h03 + i);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("pause_len5", 32'(o_state), 32'd0);

        // Looping playback on a 3-word slot, then stop with a coincident strobe.
        i_slot_sel = 2'd1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        i_loop = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            check("loop_addr", 32'(o_sram_addr), 32'h40 + (i % 3));
            check("loop_state", 32'(o_state), 32'd4);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("stop_drop_state", 32'(o_state), 32'd0);
        check("stop_drop_addr", 32'(o_sram_addr), 32'h40);

        // Random keys and strobes against the model.
        for (int c = 0; c < 800; c++) begin
            i_slot_sel = 2'($urandom_range(0, 3));
            i_loop     = 1'($urandom_range(0, 1));
            r_kr = ($urandom_range(0, 19) == 0);
            r_kp = ($urandom_range(0, 14) == 0);
            r_ks = ($urandom_range(0, 24) == 0);
            r_sr = ($urandom_range(0, 1) == 1);
            r_sp = ($urandom_range(0, 1) == 1);
            cyc(r_kr, r_kp, r_ks, r_sr, r_sp);
        end

        // Asynchronous reset in the middle of a recording discards lengths.
        i_slot_sel = 2'd0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        model_reset();
        check_all();
        check("async_rst_state", 32'(o_state), 32'd7);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("len_lost", 32'(o_state), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
